// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect and IF/ID head.
// master = fetch unit side, slave = memory/ID/branch-unit side.
interface fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        IF_valid;
  logic [31:0] IF_instr;
  logic [31:0] IF_pc;
  logic        IF_is_cf;

  modport master (
    output imem_req, imem_addr, IF_valid, IF_instr, IF_pc, IF_is_cf,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
  modport slave (
    input  imem_req, imem_addr, IF_valid, IF_instr, IF_pc, IF_is_cf,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch with an in-order prefetch queue; redirects flush and drop stale returns.
// Define FETCH_PREDECODE_EN to store a per-entry control-flow flag driving IF_is_cf.
module fetch_queue #(
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clock,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned PW  = $clog2(QDEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t [QDEPTH-1:0] ent_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [CW:0]   credits_used;
  logic [31:0]   redir_pc;
  logic [1:0]    unused_pc_lsb;
  logic          req, grant, drop, push, pop, valid;

  assign redir_pc      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_pc_lsb = bus.redirect_pc[1:0];

  always_comb begin
    credits_used = {1'b0, count_q} + {1'b0, outst_q};
    valid = (count_q != '0);
    req   = !reset && !bus.redirect && (credits_used < QDEPTH[CW:0]);
    grant = req && bus.imem_gnt;
    drop  = bus.imem_rvalid && (discard_q != '0);
    push  = !reset && bus.imem_rvalid && !drop && !bus.redirect;
    pop   = valid && !bus.stall && !bus.redirect;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;

    if (bus.redirect) begin
      // Everything still in flight is stale; a return landing this cycle is dropped here.
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - CW'(bus.imem_rvalid);
      discard_d  = outst_q - CW'(bus.imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        tail_d    = tail_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      outst_d = outst_q + CW'(grant) - CW'(bus.imem_rvalid);
      if (drop) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Payload storage needs no reset: outputs are masked by count_q.
  always_ff @(posedge clock) begin
    if (push) ent_q[tail_q] <= '{instr: bus.imem_rdata, pc: resp_pc_q};
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.IF_valid  = valid;
  assign bus.IF_instr  = valid ? ent_q[head_q].instr : NOP;
  assign bus.IF_pc     = valid ? ent_q[head_q].pc : 32'h0;

`ifdef FETCH_PREDECODE_EN
  logic [QDEPTH-1:0] cf_q;

  function automatic logic is_cf(input logic [6:0] op);
    return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
  endfunction

  always_ff @(posedge clock) begin
    if (push) cf_q[tail_q] <= is_cf(bus.imem_rdata[6:0]);
  end

  assign bus.IF_is_cf = valid && cf_q[head_q];
`else
  assign bus.IF_is_cf = 1'b0;
`endif

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count_q == QDEPTH[CW-1:0])));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: memory model pushes expected head entries,
// a monitor pops them as ID consumes; directed checks cover timing and boundaries.
module tb_fetch_queue;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_PREDECODE_EN
  localparam bit CF_EN = 1'b1;
`else
  localparam bit CF_EN = 1'b0;
`endif

  typedef struct { logic [31:0] addr; int due; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  logic clock = 1'b0;
  logic reset;
  fetch_queue_if ifc();

  fetch_queue #(.QDEPTH(4), .RESET_PC(RST_PC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc.master)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_grants = 0;
  int   lat      = 1;
  int   cyc      = 0;
  int   epoch    = 0;
  req_t pend[$];
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h0000_006F;
      32'h0000_0204: return 32'h0000_0033;
      32'h0000_0208: return 32'h0000_0063;
      default:       return {a[26:2], 7'h13};
    endcase
  endfunction

  function automatic logic cf_of(input logic [31:0] w);
    return CF_EN && (w[6:0] == 7'b1100011 || w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111);
  endfunction

  // In-order memory with programmable latency; marks returns stale across redirects.
  initial begin
    req_t        rv;
    logic [31:0] rv_addr = '0;
    int          rv_ep   = 0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend.delete();
        exp_q.delete();
      end else begin
        if (ifc.imem_rvalid && !ifc.redirect && rv_ep == epoch)
          exp_q.push_back('{pc: rv_addr, instr: mem_word(rv_addr)});
        if (ifc.redirect) begin
          epoch++;
          exp_q.delete();
        end
        if (ifc.imem_req && ifc.imem_gnt) begin
          n_grants++;
          pend.push_back('{addr: ifc.imem_addr, due: cyc + lat, ep: epoch});
        end
      end
      @(posedge clock);
      #1;
      cyc++;
      ifc.imem_rvalid = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        rv = pend.pop_front();
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = mem_word(rv.addr);
        rv_addr = rv.addr;
        rv_ep   = rv.ep;
      end
    end
  end

  // Monitor: every consumed head must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && !ifc.redirect) begin
        if (!ifc.IF_valid) begin
          chk("idle_instr", ifc.IF_instr, 32'h0000_0013);
          chk("idle_pc", ifc.IF_pc, 32'h0);
          chk("idle_cf", {31'h0, ifc.IF_is_cf}, 32'h0);
        end else if (!ifc.stall) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_pc", ifc.IF_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", ifc.IF_pc, e.pc);
            chk("sb_instr", ifc.IF_instr, e.instr);
            chk("sb_cf", {31'h0, ifc.IF_is_cf}, {31'h0, cf_of(e.instr)});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // Returns at the start of cycle 1 (first cycle with reset low).
  task automatic do_reset(input int l, input logic st);
    next();
    reset = 1'b1; ifc.redirect = 1'b0; ifc.stall = st; lat = l;
    smp();
    next();
    smp();
    chk("rst_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("rst_addr", ifc.imem_addr, RST_PC);
    chk("rst_valid", {31'h0, ifc.IF_valid}, 32'h0);
    chk("rst_instr", ifc.IF_instr, 32'h0000_0013);
    chk("rst_pc", ifc.IF_pc, 32'h0);
    chk("rst_cf", {31'h0, ifc.IF_is_cf}, 32'h0);
    next();
    reset = 1'b0;
  endtask

  initial begin
    int g0;
    reset = 1'b1;
    ifc.stall = 1'b0; ifc.redirect = 1'b0; ifc.redirect_pc = '0; ifc.imem_gnt = 1'b1;

    // Reset release, 1-cycle memory: first fetch at RESET_PC, IF_valid at cycle 3.
    do_reset(1, 1'b0);
    smp();
    chk("t1_req_c1", {31'h0, ifc.imem_req}, 32'h1);
    chk("t1_addr_c1", ifc.imem_addr, RST_PC);
    chk("t1_valid_c1", {31'h0, ifc.IF_valid}, 32'h0);
    next(); smp();
    chk("t1_valid_c2", {31'h0, ifc.IF_valid}, 32'h0);
    chk("t1_addr_c2", ifc.imem_addr, 32'h4);
    for (int i = 0; i < 5; i++) begin
      next(); smp();
      chk("t1_stream_valid", {31'h0, ifc.IF_valid}, 32'h1);
      chk("t1_stream_pc", ifc.IF_pc, 32'(i * 4));
    end

    // Stalled ID: exactly QDEPTH grants, then request held low until a pop.
    do_reset(1, 1'b1);
    g0 = n_grants;
    smp();
    for (int i = 2; i <= 10; i++) begin next(); smp(); end
    chk("t2_grants", 32'(n_grants - g0), 32'd4);
    chk("t2_req_full", {31'h0, ifc.imem_req}, 32'h0);
    chk("t2_head_pc", ifc.IF_pc, 32'h0);
    next(); ifc.stall = 1'b0; smp();
    chk("t2_req_pop_cycle", {31'h0, ifc.imem_req}, 32'h0);
    chk("t2_pc0", ifc.IF_pc, 32'h0);
    for (int i = 1; i < 4; i++) begin
      next(); smp();
      if (i == 1) chk("t2_req_resume", {31'h0, ifc.imem_req}, 32'h1);
      chk("t2_pc_order", ifc.IF_pc, 32'(i * 4));
    end
    repeat (6) begin next(); smp(); end

    // Two in flight (3-cycle memory), redirect to 0x102: both returns dropped.
    do_reset(3, 1'b0);
    smp();
    next(); smp();
    next(); ifc.redirect = 1'b1; ifc.redirect_pc = 32'h0000_0102; smp();
    chk("t3_req_redirect", {31'h0, ifc.imem_req}, 32'h0);
    next(); ifc.redirect = 1'b0; smp();
    chk("t3_req_after", {31'h0, ifc.imem_req}, 32'h1);
    chk("t3_addr_after", ifc.imem_addr, 32'h0000_0100);
    chk("t3_valid_c4", {31'h0, ifc.IF_valid}, 32'h0);
    for (int i = 5; i <= 7; i++) begin
      next(); smp();
      chk("t3_stale_dropped", {31'h0, ifc.IF_valid}, 32'h0);
    end
    next(); smp();
    chk("t3_first_valid", {31'h0, ifc.IF_valid}, 32'h1);
    chk("t3_first_pc", ifc.IF_pc, 32'h0000_0100);
    repeat (12) begin next(); smp(); end

    // Redirect coincident with a return while stalled: that return counts as dropped.
    do_reset(3, 1'b1);
    smp();
    for (int i = 2; i <= 4; i++) begin next(); smp(); end
    next(); ifc.redirect = 1'b1; ifc.redirect_pc = 32'h0000_0040; smp();
    next(); ifc.redirect = 1'b0; smp();
    chk("t4_flushed", {31'h0, ifc.IF_valid}, 32'h0);
    chk("t4_addr", ifc.imem_addr, 32'h0000_0040);
    chk("t4_req", {31'h0, ifc.imem_req}, 32'h1);
    for (int i = 7; i <= 9; i++) begin
      next(); smp();
      chk("t4_stale_dropped", {31'h0, ifc.IF_valid}, 32'h0);
    end
    next(); smp();
    chk("t4_first_valid", {31'h0, ifc.IF_valid}, 32'h1);
    chk("t4_first_pc", ifc.IF_pc, 32'h0000_0040);
    next(); ifc.stall = 1'b0; smp();
    repeat (12) begin next(); smp(); end

    // Address wrap at the top of memory; low redirect bits ignored.
    do_reset(1, 1'b0);
    smp();
    next(); ifc.redirect = 1'b1; ifc.redirect_pc = 32'hFFFF_FFFF; smp();
    next(); ifc.redirect = 1'b0; smp();
    chk("t5_addr_top", ifc.imem_addr, 32'hFFFF_FFFC);
    chk("t5_req_top", {31'h0, ifc.imem_req}, 32'h1);
    next(); smp();
    chk("t5_addr_wrap", ifc.imem_addr, 32'h0);
    chk("t5_valid_c4", {31'h0, ifc.IF_valid}, 32'h0);
    next(); smp();
    chk("t5_pc_top", ifc.IF_pc, 32'hFFFF_FFFC);
    next(); smp();
    chk("t5_pc_wrap", ifc.IF_pc, 32'h0);
    repeat (4) begin next(); smp(); end

    // Predecode: JAL, ALU op, branch.
    do_reset(1, 1'b0);
    ifc.redirect = 1'b1; ifc.redirect_pc = 32'h0000_0200;
    smp();
    next(); ifc.redirect = 1'b0; smp();
    chk("t6_addr", ifc.imem_addr, 32'h0000_0200);
    next(); smp();
    next(); smp();
    chk("t6_jal_instr", ifc.IF_instr, 32'h0000_006F);
    chk("t6_jal_cf", {31'h0, ifc.IF_is_cf}, {31'h0, CF_EN});
    next(); smp();
    chk("t6_alu_instr", ifc.IF_instr, 32'h0000_0033);
    chk("t6_alu_cf", {31'h0, ifc.IF_is_cf}, 32'h0);
    next(); smp();
    chk("t6_br_pc", ifc.IF_pc, 32'h0000_0208);
    chk("t6_br_cf", {31'h0, ifc.IF_is_cf}, {31'h0, CF_EN});

    // Stop fetching and let everything in flight drain through ID.
    next(); ifc.imem_gnt = 1'b0; smp();
    repeat (10) begin next(); smp(); end
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    chk("drain_valid", {31'h0, ifc.IF_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
